// File: rtl/serial_sub_8.sv
`default_nettype none
// ============================================================================
// serial_sub_8 : bit-serial 8-bit subtractor, d = a - b - bin, LSB first.
//   Optional signed-overflow output enabled by macro SERIAL_SUB_OVF_EN.
// Revision: 1.0
// ============================================================================
module serial_sub_8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic       busy,
  output logic       done,
  output logic [7:0] d,
  output logic       bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic       ovf
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] a_sh_q, a_sh_d;
  logic [7:0] b_sh_q, b_sh_d;
  logic [7:0] res_q, res_d;
  logic [7:0] d_q, d_d;
  logic [2:0] cnt_q, cnt_d;
  logic       br_q, br_d;
  logic       bout_q, bout_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic       w_ai, w_bi, w_diff, w_borrow;

  // Single full-subtractor cell shared by all eight bit positions
  assign w_ai     = a_sh_q[0];
  assign w_bi     = b_sh_q[0];
  assign w_diff   = w_ai ^ w_bi ^ br_q;
  assign w_borrow = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & br_q);

`ifdef SERIAL_SUB_OVF_EN
  logic a7_q, a7_d;
  logic b7_q, b7_d;
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
    a7_d    = a7_q;
    b7_d    = b7_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SHIFT;
          a_sh_d  = a;
          b_sh_d  = b;
          br_d    = bin;
          cnt_d   = 3'd0;
          res_d   = 8'h00;
          busy_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          a7_d    = a[7];
          b7_d    = b[7];
`endif
        end
      end
      SHIFT: begin
        res_d  = {w_diff, res_q[7:1]};
        br_d   = w_borrow;
        a_sh_d = {1'b0, a_sh_q[7:1]};
        b_sh_d = {1'b0, b_sh_q[7:1]};
        cnt_d  = cnt_q + 3'd1;
        // Publish on the last bit so done and the new d appear together
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          d_d     = {w_diff, res_q[7:1]};
          bout_d  = w_borrow;
          done_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
          ovf_d   = (a7_q ^ b7_q) & (a7_q ^ w_diff);
`endif
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= 8'h00;
      b_sh_q  <= 8'h00;
      res_q   <= 8'h00;
      d_q     <= 8'h00;
      cnt_q   <= 3'd0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a7_q  <= 1'b0;
      b7_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      a7_q  <= a7_d;
      b7_q  <= b7_d;
      ovf_q <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign d    = d_q;
  assign bout = bout_q;

endmodule
`default_nettype wire
